// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle RISC-V datapath.
// Ports: clk, reset (async, active-high), opcode, zero in;
//   datapath enables/mux selects, illegal, instr_done, state out.
module multicycle_control_fsm #(
  parameter bit EN_ITYPE = 1'b1,
  parameter bit EN_JAL   = 1'b1,
  parameter int STATE_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         imm_src,
  output logic               reg_write,
  output logic               illegal,
  output logic               instr_done,
  output logic [STATE_W-1:0] state
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    ALUWB    = STATE_W'(7),
    EXECUTEI = STATE_W'(8),
    JAL      = STATE_W'(9),
    BEQ      = STATE_W'(10)
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   pc_update;
  logic   branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write   = 1'b1;
        pc_update  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_d    = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        if (opcode == OP_LW || opcode == OP_SW)
          state_d = MEMADR;
        else if (opcode == OP_R)
          state_d = EXECUTER;
        else if (EN_ITYPE && opcode == OP_I)
          state_d = EXECUTEI;
        else if (EN_JAL && opcode == OP_JAL)
          state_d = JAL;
        else if (opcode == OP_BEQ)
          state_d = BEQ;
        else begin
          illegal = 1'b1;
          state_d = FETCH;
        end
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // zero feeds pc_write combinationally so a late compare
  // result still steers the branch in the BEQ cycle.
  assign pc_write = pc_update | (branch & zero);

  always_comb begin
    imm_src = 2'b00;
    unique case (1'b1)
      (opcode == OP_SW):  imm_src = 2'b01;
      (opcode == OP_BEQ): imm_src = 2'b10;
      (opcode == OP_JAL): imm_src = 2'b11;
      default:            imm_src = 2'b00;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: one full-featured
// instance and one with I-type and jal disabled.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam int N_INSTR = 200;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] opcode_a, opcode_b;
  logic zero_a, zero_b;

  always #5 clk = ~clk;

  logic pcw_a, adr_a, mw_a, irw_a, rw_a, ill_a, done_a;
  logic [1:0] rs_a, sa_a, sb_a, aop_a, imm_a;
  logic [3:0] st_a;
  logic pcw_b, adr_b, mw_b, irw_b, rw_b, ill_b, done_b;
  logic [1:0] rs_b, sa_b, sb_b, aop_b, imm_b;
  logic [3:0] st_b;

  multicycle_control_fsm u_a (
    .clk(clk), .reset(reset), .opcode(opcode_a), .zero(zero_a),
    .pc_write(pcw_a), .adr_src(adr_a), .mem_write(mw_a),
    .ir_write(irw_a), .result_src(rs_a), .alu_src_a(sa_a),
    .alu_src_b(sb_a), .alu_op(aop_a), .imm_src(imm_a),
    .reg_write(rw_a), .illegal(ill_a), .instr_done(done_a),
    .state(st_a)
  );

  multicycle_control_fsm #(.EN_ITYPE(1'b0), .EN_JAL(1'b0)) u_b (
    .clk(clk), .reset(reset), .opcode(opcode_b), .zero(zero_b),
    .pc_write(pcw_b), .adr_src(adr_b), .mem_write(mw_b),
    .ir_write(irw_b), .result_src(rs_b), .alu_src_a(sa_b),
    .alu_src_b(sb_b), .alu_op(aop_b), .imm_src(imm_b),
    .reg_write(rw_b), .illegal(ill_b), .instr_done(done_b),
    .state(st_b)
  );

  logic [16:0] out_a, out_b;
  assign out_a = {pcw_a, adr_a, mw_a, irw_a, rs_a, sa_a, sb_a,
                  aop_a, imm_a, rw_a, ill_a, done_a};
  assign out_b = {pcw_b, adr_b, mw_b, irw_b, rs_b, sa_b, sb_b,
                  aop_b, imm_b, rw_b, ill_b, done_b};

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] o;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int compared = 0;
  int mismatched = 0;
  bit mon_on = 1'b0;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endfunction

  // Expected output bundle straight from the per-state table.
  function automatic logic [16:0] model(int s, logic z,
                                        logic [6:0] op, bit ill);
    logic pcu, br, adr, mw, irw, rw, done;
    logic [1:0] rs, sa, sb, aop, imm;
    {pcu, br, adr, mw, irw, rw} = '0;
    {rs, sa, sb, aop} = '0;
    case (s)
      0: begin irw = 1; pcu = 1; sb = 2; rs = 2; end
      1: begin sa = 1; sb = 1; end
      2: begin sa = 2; sb = 1; end
      3: adr = 1;
      4: begin rs = 1; rw = 1; end
      5: begin adr = 1; mw = 1; end
      6: begin sa = 2; aop = 2; end
      7: rw = 1;
      8: begin sa = 2; sb = 1; aop = 2; end
      9: begin sa = 1; sb = 2; pcu = 1; end
      10: begin sa = 2; aop = 1; br = 1; end
      default: ;
    endcase
    if (op == OP_SW)       imm = 2'd1;
    else if (op == OP_BEQ) imm = 2'd2;
    else if (op == OP_JAL) imm = 2'd3;
    else                   imm = 2'd0;
    done = (s == 4 || s == 5 || s == 7 || s == 10);
    return {pcu | (br & z), adr, mw, irw, rs, sa, sb, aop, imm,
            rw, ill, done};
  endfunction

  // State walk of one instruction, FETCH to last state.
  function automatic void walk(logic [6:0] op, bit en_i, bit en_j,
                               output int seq[5], output int n);
    seq = '{0, 1, 0, 0, 0};
    n = 2;
    if (op == OP_LW) begin
      seq = '{0, 1, 2, 3, 4}; n = 5;
    end else if (op == OP_SW) begin
      seq = '{0, 1, 2, 5, 0}; n = 4;
    end else if (op == OP_R) begin
      seq = '{0, 1, 6, 7, 0}; n = 4;
    end else if (op == OP_I && en_i) begin
      seq = '{0, 1, 8, 7, 0}; n = 4;
    end else if (op == OP_JAL && en_j) begin
      seq = '{0, 1, 9, 7, 0}; n = 4;
    end else if (op == OP_BEQ) begin
      seq = '{0, 1, 10, 0, 0}; n = 3;
    end
  endfunction

  function automatic logic [6:0] pick_op();
    logic [6:0] ops[6];
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
    if ($urandom_range(9) < 8) return ops[$urandom_range(5)];
    return 7'($urandom);
  endfunction

  task automatic run(input int d);
    int seq[5];
    int n;
    logic [6:0] op, drv;
    logic z;
    bit en;
    exp_t e;
    en = (d == 0);
    for (int k = 0; k < N_INSTR; k++) begin
      op = pick_op();
      walk(op, en, en, seq, n);
      for (int i = 0; i < n; i++) begin
        // opcode only matters in DECODE/MEMADR; scramble it elsewhere
        drv = (seq[i] == 1 || seq[i] == 2) ? op : 7'($urandom);
        z = 1'($urandom);
        if (d == 0) begin opcode_a = drv; zero_a = z; end
        else        begin opcode_b = drv; zero_b = z; end
        e.st = 4'(seq[i]);
        e.o = model(seq[i], z, drv, (n == 2) && (seq[i] == 1));
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
        @(posedge clk);
        #1;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a_state", 32'(st_a), 32'(e.st));
        check("a_outs", 32'(out_a), 32'(e.o));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b_state", 32'(st_b), 32'(e.st));
        check("b_outs", 32'(out_b), 32'(e.o));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    opcode_a = OP_LW;
    opcode_b = OP_LW;
    zero_a = 1'b0;
    zero_b = 1'b0;
    #1;
    check("reset_state", 32'(st_a), 0);
    check("reset_outs", 32'(out_a), 32'(model(0, 0, OP_LW, 0)));
    check("reset_state_b", 32'(st_b), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("memread_state", 32'(st_a), 3);
    check("memread_outs", 32'(out_a), 32'(model(3, 0, OP_LW, 0)));
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", 32'(st_a), 0);
    check("async_rst_outs", 32'(out_a), 32'(model(0, 0, OP_LW, 0)));
    check("async_rst_b", 32'(st_b), 0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_state", 32'(st_a), 1);
    reset = 1'b1;
    #2 reset = 1'b0;
    mon_on = 1'b1;
    fork
      run(0);
      run(1);
    join
    mon_on = 1'b0;
    check("q_a_drained", 32'(q_a.size()), 0);
    check("q_b_drained", 32'(q_b.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore control FSM for the multicycle RISC-V datapath; successor to the single-cycle main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath enables and muxes from the current state, with immediate format decoded from opcode.
- Optional instruction classes are enabled per build by parameter; unsupported or unknown opcodes raise a one-cycle illegal flag and return to fetch.

Parameters:
- EN_ITYPE, 1, 1 enables I-type ALU (opcode 0010011); 0 treats it as illegal.
- EN_JAL, 1, 1 enables jal (opcode 1101111); 0 treats it as illegal.
- STATE_W, 4, width of the state register (minimum 4).

Ports:
- clk  in  1  clock, rising-edge active
- reset  in  1  asynchronous, active-high; forces FETCH
- opcode  in  7  instr[6:0] from the instruction register; stable after FETCH
- zero  in  1  ALU zero flag
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction register / old-PC enable
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 data
- alu_src_b  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- reg_write  out  1  register file write enable
- illegal  out  1  one-cycle pulse for an unknown or disabled opcode
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- state  out  STATE_W  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10.
- Other encodings are unreachable; if entered, the next state is FETCH.
- Reset: state=FETCH immediately, asynchronously.
  - Outputs then show FETCH values.
  - Reset mid-instruction abandons the instruction with no further writes.
- Transitions, one state per clock:
  - FETCH -> DECODE.
  - DECODE on opcode:
    - 0000011 / 0100011 -> MEMADR.
    - 0110011 -> EXECUTER.
    - 0010011 -> EXECUTEI if EN_ITYPE.
    - 1101111 -> JAL if EN_JAL.
    - 1100011 -> BEQ.
    - Any other opcode -> FETCH with illegal=1 during that DECODE cycle.
  - MEMADR: lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER / EXECUTEI / JAL -> ALUWB -> FETCH.
  - BEQ -> FETCH.
- Outputs are Moore (state only). Exceptions: pc_write also uses zero; imm_src is combinational from opcode.
- Per-state outputs; any signal not listed is 0, never X:
  - FETCH: ir_write=1, pc_update=1, alu_src_b=10, result_src=10.
  - DECODE: alu_src_a=01, alu_src_b=01.
  - MEMADR: alu_src_a=10, alu_src_b=01.
  - MEMREAD: adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=1.
  - EXECUTER: alu_src_a=10, alu_op=10.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10.
  - ALUWB: reg_write=1.
  - JAL: alu_src_a=01, alu_src_b=10, pc_update=1.
  - BEQ: alu_src_a=10, alu_op=01, branch=1.
- pc_write = pc_update | (branch & zero).
  - pc_update and branch are internal signals.
  - In BEQ, a change on zero propagates to pc_write in the same cycle.
- imm_src by opcode:
  - lw, I-type: 00.
  - sw: 01.
  - beq: 10.
  - jal: 11.
  - R-type and unknown opcodes: 00.
- instr_done=1 in MEMWB, MEMWRITE, ALUWB and BEQ.
- Instruction latency, FETCH to return to FETCH:
  - lw: 5 cycles.
  - sw, R-type, I-type, jal: 4 cycles.
  - beq: 3 cycles.
  - illegal: 2 cycles.
- opcode is sampled only in DECODE and MEMADR; changes in other states have no effect.

Test Plan:
- Reset asserted mid-MEMREAD for half a cycle -> state=0 before the next edge; ir_write=1, pc_write=1, alu_src_b=10, result_src=10 with no clock edge.
- opcode=0000011, 5 clocks -> states 0,1,2,3,4; reg_write=1 and result_src=01 only in state 4; instr_done=1 only in state 4; back to 0.
- opcode=0100011 -> states 0,1,2,5; mem_write=1 and adr_src=1 in state 5; imm_src=01; reg_write=0 throughout.
- opcode=1100011 in BEQ: zero=1 -> pc_write=1, alu_op=01; zero=0 -> pc_write=0; in both cases imm_src=10, next state 0.
- EN_JAL=1, opcode=1101111 -> states 0,1,9,7; pc_write=1 in 9, reg_write=1 in 7. EN_JAL=0 -> illegal=1 in state 1, next state 0, no reg_write or mem_write.
- opcode=0110011 then 0010011 (EN_ITYPE=1) -> states 1,6,7 with alu_src_b=00, then 1,8,7 with alu_src_b=01; alu_op=10 in 6 and 8.
